mem_store_buffer_ctrl: RTL and testbench
========================================

// Module: mem_store_buffer_ctrl
// PURPOSE
//  Memory-access controller that sits directly upstream of the main memory.
//  Takes CPU load/store requests over a valid/ready handshake.
//  Buffers stores in a small FIFO and drains them to memory when the port is idle.
//  Loads are served by store-to-load forwarding or by a main-memory read timed
//  to the memory's negedge read capture.
// PARAMETERS
//  WORD_SIZE  32  data word width; must match main memory word_size
//  ADDR_BITS  5   word address width; must match main memory memory_bits
//  SB_DEPTH   4   store-buffer entries; power of two, >=2
// PORTS
//  clk        in   1          single clock; all state updates on posedge
//  reset      in   1          asynchronous, active-low; 0 clears all state immediately
//  req_valid  in   1          CPU request present
//  req_ready  out  1          request accepted on posedge when req_valid&req_ready
//  req_write  in   1          1=store, 0=load
//  req_addr   in   ADDR_BITS  word address
//  req_wdata  in   WORD_SIZE  store data
//  rsp_valid  out  1          one-cycle pulse: load data valid
//  rsp_rdata  out  WORD_SIZE  load data; holds last value between pulses
//  mem_address out ADDR_BITS  to main memory address
//  mem_write  out  1          to write_signal_memory; memory writes on next posedge
//  mem_read   out  1          to read_signal_memory; memory captures on negedge
//  mem_wdata  out  WORD_SIZE  to write_data
//  mem_rdata  in   WORD_SIZE  from memory_out
//  sb_count   out  $clog2(SB_DEPTH)+1  entries held
//  sb_full / sb_empty  out  1  buffer status
// BEHAVIOUR
//  Reset (reset=0): all outputs 0 except sb_empty=1; buffered stores are discarded;
//    FSM returns to IDLE. This applies mid-read and mid-drain.
//  FSM states: IDLE, RD.
//    IDLE->RD on accepting a load miss; RD->IDLE after one cycle.
//  mem_* outputs are registered and default to 0 each cycle unless set below.
//  req_ready:
//    store: !sb_full.
//    load: state==IDLE && !sb_full.
//  Store accept: enqueue {addr,data} at tail; no response.
//  Load accept, hit (a buffered entry matches the address):
//    take the YOUNGEST matching entry; rsp_rdata<=entry; rsp_valid=1 in the cycle
//    after the accept edge; no mem_read; stay IDLE.
//  Load accept, miss:
//    mem_read<=1, mem_address<=addr, go to RD. Memory captures on the negedge of
//    that cycle. At the next posedge: rsp_rdata<=mem_rdata, rsp_valid=1, go to IDLE.
//    Total latency is 2 edges after accept.
//  Drain: when state==IDLE and !sb_empty and (sb_full or !req_valid):
//    pop head; mem_write<=1, mem_address/mem_wdata<=head.
//    One pop per cycle; back-to-back pops allowed.
//  A load is never accepted in the same cycle as a pop.
//    This is safe: a miss means no buffered store to that address.
//    Any earlier popped write has landed by the edge that starts the read.
//  Store accept together with a pop: count unchanged; full-to-full is impossible
//    because a store is refused while full.
//  Pointers wrap modulo SB_DEPTH. sb_count saturates at SB_DEPTH; it never
//    overflows or underflows.
//  Stores in RD are accepted if not full. Drain is suppressed in RD.
// STRUCTURE
//  Shared package mem_pkg: WORD_SIZE, ADDR_BITS constants; state enum {IDLE,RD};
//    store-buffer entry struct {addr,data}.
//  Sub-module store_buffer_fifo: circular FIFO with push/pop, count/full/empty,
//    and a combinational youngest-match lookup (hit, data).
//  The top level holds the FSM, the handshake logic, and the registered mem_* drive.
// TESTING
//  1 Reset: drop reset to 0 while in RD with 2 entries buffered
//    -> rsp_valid=0, mem_*=0, sb_count=0, sb_empty=1 immediately.
//  2 Store @5=0xDEADBEEF, then req_valid=0
//    -> next cycle mem_write=1, addr=5, data=0xDEADBEEF.
//    Then load @5 -> miss, rsp 0xDEADBEEF 2 edges after accept.
//  3 Back-to-back stores @3=0x11, @7=0x22, @3=0x33, then load @3
//    -> rsp_valid next cycle with data 0x33 (youngest), mem_read stays 0.
//  4 Four back-to-back stores fill the buffer (sb_full=1). A 5th store
//    -> req_ready=0 and head pops (mem_write=1) that cycle; accepted the next cycle.
//  5 Load @9 with memory cleared -> rsp 0x0 after 2 edges.
//    A second load presented during RD sees req_ready=0 until IDLE.
//  6 After test 4, hold req_valid=0
//    -> mem_write high for 4 consecutive cycles, FIFO order; then sb_empty=1.

Source files
------------

// File: rtl/mem_store_buffer_ctrl_pkg.sv
// Shared constants and types for the store-buffered memory-access controller.
// Word and address widths must track the main memory's word_size and memory_bits.
package mem_store_buffer_ctrl_pkg;

   localparam int WORD_SIZE = 32;
   localparam int ADDR_BITS = 5;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RD   = 1'b1;

   typedef struct packed {
      logic [ADDR_BITS-1:0] addr;
      logic [WORD_SIZE-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer_ctrl_if.sv
// CPU-side request/response channel: valid/ready request, single-cycle response pulse.
// master = CPU, slave = controller.
interface mem_store_buffer_ctrl_if
   import mem_store_buffer_ctrl_pkg::*;
   ();

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [ADDR_BITS-1:0] req_addr;
   logic [WORD_SIZE-1:0] req_wdata;
   logic                 rsp_valid;
   logic [WORD_SIZE-1:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/mem_store_buffer_ctrl_fifo.sv
// Circular store buffer with push/pop, occupancy flags and a combinational
// youngest-match address lookup used for store-to-load forwarding.
module mem_store_buffer_ctrl_fifo
   import mem_store_buffer_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  sb_entry_t              i_push_entry,
   input  logic                   i_pop,
   output sb_entry_t              o_head,
   input  logic [ADDR_BITS-1:0]   i_lookup_addr,
   output logic                   o_hit,
   output logic [WORD_SIZE-1:0]   o_hit_data,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   sb_entry_t       r_mem [DEPTH];
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [CW-1:0]   r_count;
   logic            w_push;
   logic            w_pop;
   logic [PW-1:0]   w_idx;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_head  = r_mem[r_head];
   assign o_count = r_count;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + PW'(1);
         if (w_pop)  r_head <= r_head + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: entry storage is not reset; r_count gates every read so stale slots are never observed.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_tail] <= i_push_entry;
   end

   // Walk oldest to youngest so the last match left standing is the youngest store.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      o_hit      = 1'b0;
      o_hit_data = '0;
      w_idx      = r_head;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_head + PW'(i);
         if ((CW'(i) < r_count) && (r_mem[w_idx].addr == i_lookup_addr)) begin
            o_hit      = 1'b1;
            o_hit_data = r_mem[w_idx].data;
         end
      end
   end

endmodule

// File: rtl/mem_store_buffer_ctrl.sv
// Memory-access controller: buffers CPU stores, drains them when the port is idle,
// and serves loads by forwarding or by a one-cycle negedge-captured memory read.
module mem_store_buffer_ctrl
   import mem_store_buffer_ctrl_pkg::*;
#(
   parameter int SB_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   mem_store_buffer_ctrl_if.slave    cpu,
   output logic [ADDR_BITS-1:0]      mem_address,
   output logic                      mem_write,
   output logic                      mem_read,
   output logic [WORD_SIZE-1:0]      mem_wdata,
   input  logic [WORD_SIZE-1:0]      mem_rdata,
   output logic [$clog2(SB_DEPTH):0] sb_count,
   output logic                      sb_full,
   output logic                      sb_empty
);

   logic [0:0]           r_state;
   logic                 r_rsp_valid;
   logic [WORD_SIZE-1:0] r_rsp_rdata;
   logic [ADDR_BITS-1:0] r_mem_address;
   logic                 r_mem_write;
   logic                 r_mem_read;
   logic [WORD_SIZE-1:0] r_mem_wdata;

   logic                 w_ready;
   logic                 w_store;
   logic                 w_load;
   logic                 w_pop;
   logic                 w_hit;
   logic [WORD_SIZE-1:0] w_hit_data;
   sb_entry_t            w_head;

   // Loads also wait for IDLE; a pop only happens with no acceptable load present.
   assign w_ready = cpu.req_write ? !sb_full : ((r_state == IDLE) && !sb_full);
   assign w_store = cpu.req_valid && w_ready && cpu.req_write;
   assign w_load  = cpu.req_valid && w_ready && !cpu.req_write;
   assign w_pop   = (r_state == IDLE) && !sb_empty && (sb_full || !cpu.req_valid);

   mem_store_buffer_ctrl_fifo #(.DEPTH(SB_DEPTH)) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .i_push        (w_store),
      .i_push_entry  ('{addr: cpu.req_addr, data: cpu.req_wdata}),
      .i_pop         (w_pop),
      .o_head        (w_head),
      .i_lookup_addr (cpu.req_addr),
      .o_hit         (w_hit),
      .o_hit_data    (w_hit_data),
      .o_count       (sb_count),
      .o_full        (sb_full),
      .o_empty       (sb_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_mem_address <= '0;
         r_mem_write   <= 1'b0;
         r_mem_read    <= 1'b0;
         r_mem_wdata   <= '0;
      end else begin
         r_rsp_valid   <= 1'b0;
         r_mem_address <= '0;
         r_mem_write   <= 1'b0;
         r_mem_read    <= 1'b0;
         r_mem_wdata   <= '0;
         case (r_state)
            IDLE: begin
               if (w_load && w_hit) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= w_hit_data;
               end else if (w_load) begin
                  r_mem_read    <= 1'b1;
                  r_mem_address <= cpu.req_addr;
                  r_state       <= RD;
               end else if (w_pop) begin
                  r_mem_write   <= 1'b1;
                  r_mem_address <= w_head.addr;
                  r_mem_wdata   <= w_head.data;
               end
            end
            default: begin
               // Memory captured on the negedge of this cycle; its output is stable here.
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= mem_rdata;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign cpu.req_ready = w_ready;
   assign cpu.rsp_valid = r_rsp_valid;
   assign cpu.rsp_rdata = r_rsp_rdata;
   assign mem_address   = r_mem_address;
   assign mem_write     = r_mem_write;
   assign mem_read      = r_mem_read;
   assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_mem_store_buffer_ctrl.sv
// Directed bench for mem_store_buffer_ctrl: per-cycle vector table plus
// hand-written sequences for the read-stall and mid-read reset corners.
module tb_mem_store_buffer_ctrl;

   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   typedef struct {
      logic        v;
      logic        w;
      logic [4:0]  a;
      logic [31:0] d;
      logic        e_ready;
      logic        e_rv;
      logic [31:0] e_rd;
      logic        e_mw;
      logic        e_mr;
      logic [4:0]  e_ma;
      logic [31:0] e_mwd;
      int          e_cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  mem_address;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [2:0]  sb_count;
   logic        sb_full;
   logic        sb_empty;

   logic        mem_clr = 1'b0;
   logic        poke_en = 1'b0;
   logic [4:0]  poke_addr = '0;
   logic [31:0] poke_data = '0;
   logic [31:0] mem_model [32];

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   mem_store_buffer_ctrl_if bus ();

   mem_store_buffer_ctrl #(.SB_DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .cpu         (bus),
      .mem_address (mem_address),
      .mem_write   (mem_write),
      .mem_read    (mem_read),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .sb_count    (sb_count),
      .sb_full     (sb_full),
      .sb_empty    (sb_empty)
   );

   always #5 clk = ~clk;

   // Main memory model: writes on posedge, read capture on negedge.
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int k = 0; k < 32; k++) mem_model[k] <= '0;
      end
      if (poke_en) mem_model[poke_addr] <= poke_data;
      if (mem_write) mem_model[mem_address] <= mem_wdata;
   end

   always @(negedge clk) begin
      if (mem_read) mem_rdata <= mem_model[mem_address];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic [31:0] d);
      bus.req_valid = v;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
   endtask

   task automatic check_outs(input string tag, input logic rv, input logic [31:0] rd,
                             input logic mw, input logic mr, input logic [4:0] ma,
                             input logic [31:0] mwd, input int cnt);
      check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(rv));
      check({tag, " rsp_rdata"}, bus.rsp_rdata, rd);
      check({tag, " mem_write"}, 32'(mem_write), 32'(mw));
      check({tag, " mem_read"}, 32'(mem_read), 32'(mr));
      check({tag, " mem_address"}, 32'(mem_address), 32'(ma));
      check({tag, " mem_wdata"}, mem_wdata, mwd);
      check({tag, " sb_count"}, 32'(sb_count), 32'(cnt));
      check({tag, " sb_full"}, 32'(sb_full), 32'(cnt == 4));
      check({tag, " sb_empty"}, 32'(sb_empty), 32'(cnt == 0));
   endtask

   function automatic vec_t mk(logic v, logic w, logic [4:0] a, logic [31:0] d, logic r,
                               logic rv, logic [31:0] rd, logic mw, logic mr,
                               logic [4:0] ma, logic [31:0] mwd, int c);
      vec_t x;
      x.v = v; x.w = w; x.a = a; x.d = d; x.e_ready = r;
      x.e_rv = rv; x.e_rd = rd; x.e_mw = mw; x.e_mr = mr;
      x.e_ma = ma; x.e_mwd = mwd; x.e_cnt = c;
      return x;
   endfunction

   initial begin
      reset = 1'b0;
      drive(F, F, 5'd0, 32'h0);
      for (int k = 0; k < 32; k++) mem_model[k] = '0;

      // Store @5 drains when idle, then a load @5 misses and reads it back.
      vecs.push_back(mk(T, T, 5'd5, 32'hDEADBEEF, T, F, 32'h0, F, F, 5'd0, 32'h0, 1));
      vecs.push_back(mk(F, F, 5'd0, 32'h0, T, F, 32'h0, T, F, 5'd5, 32'hDEADBEEF, 0));
      vecs.push_back(mk(T, F, 5'd5, 32'h0, T, F, 32'h0, F, T, 5'd5, 32'h0, 0));
      vecs.push_back(mk(F, F, 5'd0, 32'h0, F, T, 32'hDEADBEEF, F, F, 5'd0, 32'h0, 0));
      // Youngest-match forwarding, then drain in FIFO order.
      vecs.push_back(mk(T, T, 5'd3, 32'h11, T, F, 32'hDEADBEEF, F, F, 5'd0, 32'h0, 1));
      vecs.push_back(mk(T, T, 5'd7, 32'h22, T, F, 32'hDEADBEEF, F, F, 5'd0, 32'h0, 2));
      vecs.push_back(mk(T, T, 5'd3, 32'h33, T, F, 32'hDEADBEEF, F, F, 5'd0, 32'h0, 3));
      vecs.push_back(mk(T, F, 5'd3, 32'h0, T, T, 32'h33, F, F, 5'd0, 32'h0, 3));
      vecs.push_back(mk(F, F, 5'd0, 32'h0, T, F, 32'h33, T, F, 5'd3, 32'h11, 2));
      vecs.push_back(mk(F, F, 5'd0, 32'h0, T, F, 32'h33, T, F, 5'd7, 32'h22, 1));
      vecs.push_back(mk(F, F, 5'd0, 32'h0, T, F, 32'h33, T, F, 5'd3, 32'h33, 0));
      // Fill to full; 5th store refused while head pops, accepted next cycle.
      vecs.push_back(mk(T, T, 5'd1, 32'hA1, T, F, 32'h33, F, F, 5'd0, 32'h0, 1));
      vecs.push_back(mk(T, T, 5'd2, 32'hA2, T, F, 32'h33, F, F, 5'd0, 32'h0, 2));
      vecs.push_back(mk(T, T, 5'd3, 32'hA3, T, F, 32'h33, F, F, 5'd0, 32'h0, 3));
      vecs.push_back(mk(T, T, 5'd4, 32'hA4, T, F, 32'h33, F, F, 5'd0, 32'h0, 4));
      vecs.push_back(mk(T, T, 5'd6, 32'hA6, F, F, 32'h33, T, F, 5'd1, 32'hA1, 3));
      vecs.push_back(mk(T, T, 5'd6, 32'hA6, T, F, 32'h33, F, F, 5'd0, 32'h0, 4));
      // Idle: four consecutive drains in FIFO order, then empty.
      vecs.push_back(mk(F, F, 5'd0, 32'h0, F, F, 32'h33, T, F, 5'd2, 32'hA2, 3));
      vecs.push_back(mk(F, F, 5'd0, 32'h0, T, F, 32'h33, T, F, 5'd3, 32'hA3, 2));
      vecs.push_back(mk(F, F, 5'd0, 32'h0, T, F, 32'h33, T, F, 5'd4, 32'hA4, 1));
      vecs.push_back(mk(F, F, 5'd0, 32'h0, T, F, 32'h33, T, F, 5'd6, 32'hA6, 0));
      vecs.push_back(mk(F, F, 5'd0, 32'h0, T, F, 32'h33, F, F, 5'd0, 32'h0, 0));

      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", F, 32'h0, F, F, 5'd0, 32'h0, 0);
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d);
         #1;
         check($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(vecs[i].e_ready));
         @(posedge clk);
         #1;
         check_outs($sformatf("v%0d", i), vecs[i].e_rv, vecs[i].e_rd, vecs[i].e_mw,
                    vecs[i].e_mr, vecs[i].e_ma, vecs[i].e_mwd, vecs[i].e_cnt);
      end

      // Load @9 from cleared memory; a second load waits out RD.
      @(negedge clk);
      drive(F, F, 5'd0, 32'h0);
      mem_clr = 1'b1; poke_en = 1'b1; poke_addr = 5'd10; poke_data = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      mem_clr = 1'b0; poke_en = 1'b0;
      check_outs("t5 idle", F, 32'h33, F, F, 5'd0, 32'h0, 0);
      @(negedge clk);
      drive(T, F, 5'd9, 32'h0);
      #1;
      check("t5 ld9 ready", 32'(bus.req_ready), 32'(T));
      @(posedge clk);
      #1;
      check_outs("t5 ld9 acc", F, 32'h33, F, T, 5'd9, 32'h0, 0);
      @(negedge clk);
      drive(T, F, 5'd10, 32'h0);
      #1;
      check("t5 ld10 ready in RD", 32'(bus.req_ready), 32'(F));
      @(posedge clk);
      #1;
      check_outs("t5 ld9 rsp", T, 32'h0, F, F, 5'd0, 32'h0, 0);
      @(negedge clk);
      #1;
      check("t5 ld10 ready idle", 32'(bus.req_ready), 32'(T));
      @(posedge clk);
      #1;
      check_outs("t5 ld10 acc", F, 32'h0, F, T, 5'd10, 32'h0, 0);
      @(negedge clk);
      drive(F, F, 5'd0, 32'h0);
      @(posedge clk);
      #1;
      check_outs("t5 ld10 rsp", T, 32'hCAFEF00D, F, F, 5'd0, 32'h0, 0);

      // Reset asserted mid-read with two stores buffered.
      @(negedge clk);
      drive(T, T, 5'd1, 32'h1);
      @(posedge clk);
      #1;
      check_outs("t1 st1", F, 32'hCAFEF00D, F, F, 5'd0, 32'h0, 1);
      @(negedge clk);
      drive(T, T, 5'd2, 32'h2);
      @(posedge clk);
      #1;
      check_outs("t1 st2", F, 32'hCAFEF00D, F, F, 5'd0, 32'h0, 2);
      @(negedge clk);
      drive(T, F, 5'd8, 32'h0);
      #1;
      check("t1 ld8 ready", 32'(bus.req_ready), 32'(T));
      @(posedge clk);
      #1;
      check_outs("t1 ld8 acc", F, 32'hCAFEF00D, F, T, 5'd8, 32'h0, 2);
      #2;
      reset = 1'b0;
      #1;
      check_outs("t1 async reset", F, 32'h0, F, F, 5'd0, 32'h0, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      drive(T, F, 5'd1, 32'h0);
      #1;
      check("t1 post-reset ready", 32'(bus.req_ready), 32'(T));
      @(posedge clk);
      #1;
      check_outs("t1 ld1 miss", F, 32'h0, F, T, 5'd1, 32'h0, 0);
      @(negedge clk);
      drive(F, F, 5'd0, 32'h0);
      @(posedge clk);
      #1;
      check_outs("t1 ld1 rsp", T, 32'h0, F, F, 5'd0, 32'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
